bram_rd_arbiter: RTL
====================

// Module: bram_rd_arbiter
// PURPOSE
//  Shares the single read port of one BRAM bank between NB_REQ read requesters.
//  - Grants at most one request per cycle; round-robin by default.
//  - Drives the bank read port and tracks each grant through the RAM read latency.
//  - Returns read data to the granted requester.
//  - Instantiated once per bank, ahead of the bank's rden/rdaddr/rddata.
// PARAMETERS
//  NB_REQ      4   number of read requesters, 2..16
//  ADDR_WIDTH  8   bank address width in bits
//  DATA_WIDTH  32  bank data width in bits
//  RD_LATENCY  1   cycles from ram_rden to valid ram_rddata, 1..4
// PORTS
//  aclk        in   1                  single clock, all logic on rising edge
//  aresetn     in   1                  reset, asynchronous, active-low
//  req_valid   in   NB_REQ             per-requester read request
//  req_ready   out  NB_REQ             one-hot grant; a transfer occurs when valid & ready
//  req_addr    in   ADDR_WIDTH*NB_REQ  packed addresses, requester i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//  rsp_valid   out  NB_REQ             one-hot; read data valid for requester i
//  rsp_data    out  DATA_WIDTH         read data, shared by all requesters, qualified by rsp_valid
//  ram_rden    out  1                  bank read enable
//  ram_rdaddr  out  ADDR_WIDTH         bank read address
//  ram_rddata  in   DATA_WIDTH         bank read data, RD_LATENCY cycles after ram_rden
// BEHAVIOUR
//  - Reset (aresetn low) is asynchronous:
//    - rr_ptr=0; latency pipe cleared; rsp_valid=0.
//    - req_ready=0 and ram_rden=0 while aresetn is low.
//  - Arbitration (combinational) searches req_valid starting at index rr_ptr, wrapping at NB_REQ-1 -> 0.
//    - The first set bit is the grant g; req_ready = onehot(g).
//    - No valid bit set -> req_ready=0.
//  - Port drive:
//    - ram_rden = |req_ready.
//    - ram_rdaddr = req_addr slice g, or 0 when no grant.
//  - Pointer update: on a granted cycle, rr_ptr <= (g+1) mod NB_REQ; otherwise it holds.
//  - Fairness: a continuously valid requester is granted within NB_REQ cycles.
//  - Handshake rules:
//    - req_ready may depend on req_valid.
//    - A requester keeps req_valid high and req_addr stable until it sees ready.
//    - Dropping valid before ready is legal and cancels the request.
//  - Latency pipe: RD_LATENCY-deep shift register of NB_REQ-bit one-hot grant vectors.
//    - Stage 0 <= req_ready.
//    - rsp_valid = last stage; rsp_data = ram_rddata, passed through without a register.
//    - Request-to-response latency is exactly RD_LATENCY cycles.
//    - Back-to-back grants give back-to-back responses, in order.
//  - No response backpressure: a requester must accept rsp_valid in the cycle it is asserted.
//  - Boundary conditions:
//    - rr_ptr at NB_REQ-1 with the grant on NB_REQ-1 -> rr_ptr wraps to 0.
//    - A single requester may be granted every cycle (100% port use).
//    - Reset mid-operation drops all in-flight reads; none are replayed.
// CONFIGURATION
//  BRAM_ARB_FIXED_PRIO_EN
//    - Defined: fixed priority, lowest index wins.
//      - rr_ptr is removed (tied to 0).
//      - Requester 0 can starve all others.
//    - Undefined (default): round-robin as above.
//    - Ports, latency and response behaviour are identical in both modes.
// TESTING (NB_REQ=4, ADDR_WIDTH=8, DATA_WIDTH=32, RD_LATENCY=2, bank preloaded mem[a]=0xA5000000+a)
//  1 Single: req_valid=4'b0100, addr2=0x10 at cycle T
//    -> req_ready=4'b0100 and ram_rden=1, ram_rdaddr=0x10 at T
//    -> rsp_valid=4'b0100, rsp_data=0xA5000010 at T+2.
//  2 All valid every cycle, addr_i=i -> grants 0,1,2,3,0,1,... one per cycle
//    -> rsp_valid follows the same sequence 2 cycles later, data 0xA5000000+i.
//  3 Last grant to 1 (rr_ptr=2), then req_valid=4'b1001 -> grant 3, then 0; rr_ptr ends at 1.
//  4 Grant to requester 1 at T, aresetn low for 1 cycle at T+1
//    -> rsp_valid stays 0 through T+3; rr_ptr=0.
//    -> After release, req_valid=4'b1111 -> grant 0 first.
//  5 Idle: req_valid=0 for 10 cycles -> ram_rden=0, rsp_valid=0, rr_ptr unchanged.
//  6 With BRAM_ARB_FIXED_PRIO_EN and all valid for 8 cycles -> req_ready=4'b0001 every cycle.

Source files
------------

// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter
//   Shares the single read port of one BRAM bank among NB_REQ requesters.
//   At most one request is granted per cycle. Each grant is tracked through
//   the RAM read latency so that the returned data reaches the right requester.
//   By default the grant rotates round-robin. When BRAM_ARB_FIXED_PRIO_EN is
//   defined, the lowest index always wins and the rotating pointer is tied to 0.
//   Reset is asynchronous and active-low (aresetn).
module bram_rd_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NB_REQ-1:0]            req_valid,
  output logic [NB_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH*NB_REQ-1:0] req_addr,
  output logic [NB_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         ram_rden,
  output logic [ADDR_WIDTH-1:0]        ram_rdaddr,
  input  logic [DATA_WIDTH-1:0]        ram_rddata
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_found;
  logic                  grant_ok;
  logic [PTR_W:0]        cand;
  logic [NB_REQ-1:0]     grant_vec;
  logic [ADDR_WIDTH-1:0] addr_arr [NB_REQ];
  logic [NB_REQ-1:0]     pipe     [RD_LATENCY];

  // Unpack the flat address bus so that the granted slice can be selected by index.
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      addr_arr[i] = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
    end
  end

  // Find the first valid request at or after rr_ptr, wrapping NB_REQ-1 -> 0.
  always_comb begin
    // NOTE: every variable gets a default before any branch. A path that
    // leaves a variable unassigned would make synthesis infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NB_REQ)) begin
        cand = cand - (PTR_W+1)'(NB_REQ);
      end
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // While reset is held, the bank port and the grant stay quiet.
  assign grant_ok = grant_found & aresetn;

  // Turn the grant into a one-hot ready vector and drive the bank port.
  always_comb begin
    grant_vec  = '0;
    ram_rdaddr = '0;
    if (grant_ok) begin
      grant_vec[grant_idx] = 1'b1;
      ram_rdaddr           = addr_arr[grant_idx];
    end
  end

  assign req_ready = grant_vec;
  assign ram_rden  = grant_ok;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  always_comb begin
    rr_ptr = '0;
  end
`else
  logic [PTR_W-1:0] next_ptr;

  // The pointer moves to the slot after the winner and wraps at NB_REQ-1.
  always_comb begin
    next_ptr = '0;
    if (grant_idx != PTR_W'(NB_REQ-1)) begin
      next_ptr = grant_idx + PTR_W'(1);
    end
  end

  // The round-robin pointer advances only on cycles that carry a grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its inputs as they were before the clock edge.
    if (!aresetn) begin
      rr_ptr <= '0;
    end else if (grant_ok) begin
      rr_ptr <= next_ptr;
    end
  end
`endif

  // The latency pipe carries each one-hot grant alongside the RAM read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: this small register array is reset explicitly. In-flight reads
      // must disappear on reset; a real RAM array would be left unreset.
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= grant_vec;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rsp_valid = pipe[RD_LATENCY-1];
  assign rsp_data  = ram_rddata;

endmodule
